uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Arbitrates byte requests from NUM_REQ sources onto a single UART
//   transmitter. Unlocked arbitration is round-robin. A requester whose byte
//   is not marked last keeps the grant (packet lock) until its last byte.
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   req_valid   per-requester pending-byte flag
//   req_data    per-requester byte, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last    per-requester end-of-packet marker
//   req_ready   one-cycle pulse on the requester whose byte was taken
//   tx_data     byte presented to the transmitter, held until the next issue
//   tx_start    one-cycle frame-start pulse
//   tx_busy     transmitter busy (start bit through stop bit)
//   grant_id    current or last granted requester
//   pkt_active  packet lock held
//   byte_count  bytes issued since reset, wraps at 16 bits
module uart_tx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_start,
  input  logic                          tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          pkt_active,
  output logic [15:0]                   byte_count
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [GW-1:0]      LAST_IDX_C = GW'(NUM_REQ - 1);
  localparam logic [GW-1:0]      IDX_ONE_C  = GW'(1);
  localparam logic [NUM_REQ-1:0] ONEHOT_C   = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic                    issue_s;
  logic                    sel_found_s;
  logic [GW-1:0]           sel_idx_s;
  logic [GW-1:0]           grant_r;
  logic [GW-1:0]           rr_ptr_r;
  logic                    pkt_active_r;
  logic [15:0]             byte_count_r;
  logic [DATA_WIDTH-1:0]   tx_data_r;
  logic                    tx_start_r;
  logic [NUM_REQ-1:0]      req_ready_r;

  // Index that is k positions after ptr, wrapping at NUM_REQ.
  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end else begin
      s = s;
    end
    return s[GW-1:0];
  endfunction

  // Eligible-set selection: the lock owner only, or the first valid at/after rr_ptr.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    if (pkt_active_r) begin
      sel_found_s = req_valid[grant_r];
      sel_idx_s   = grant_r;
    end else begin
      // Scan from the far end so the closest valid index to rr_ptr wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (req_valid[rr_idx(rr_ptr_r, k)]) begin
          sel_found_s = 1'b1;
          sel_idx_s   = rr_idx(rr_ptr_r, k);
        end else begin
          sel_found_s = sel_found_s;
        end
      end
    end
  end

  // Next-state logic; issue_s marks the IDLE->ISSUE edge where the grant is taken.
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!tx_busy && sel_found_s) begin
          state_s = ISSUE;
          issue_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        state_s = WAIT_ACK;
      end
      WAIT_ACK: begin
        // A busy drop before busy is seen is outside the contract; keep waiting.
        if (tx_busy) begin
          state_s = WAIT_DONE;
        end else begin
          state_s = WAIT_ACK;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register, grant capture, registered outputs, lock and counter update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= '0;
      rr_ptr_r     <= '0;
      pkt_active_r <= 1'b0;
      byte_count_r <= 16'd0;
      tx_data_r    <= '0;
      tx_start_r   <= 1'b0;
      req_ready_r  <= '0;
    end else begin
      state_r    <= state_s;
      tx_start_r <= issue_s;
      if (issue_s) begin
        // Byte is captured on the grant edge so it is already valid in ISSUE.
        grant_r     <= sel_idx_s;
        tx_data_r   <= req_data[sel_idx_s*DATA_WIDTH +: DATA_WIDTH];
        req_ready_r <= ONEHOT_C << sel_idx_s;
      end else begin
        req_ready_r <= '0;
      end
      if (state_r == ISSUE) begin
        byte_count_r <= byte_count_r + 16'd1;
        if (req_last[grant_r]) begin
          pkt_active_r <= 1'b0;
          rr_ptr_r     <= (grant_r == LAST_IDX_C) ? '0 : grant_r + IDX_ONE_C;
        end else begin
          pkt_active_r <= 1'b1;
        end
      end else begin
        byte_count_r <= byte_count_r;
      end
    end
  end

  assign req_ready  = req_ready_r;
  assign tx_data    = tx_data_r;
  assign tx_start   = tx_start_r;
  assign grant_id   = grant_r;
  assign pkt_active = pkt_active_r;
  assign byte_count = byte_count_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a queue-based requester model
// and a transmitter model that holds tx_busy for BUSY_LEN cycles per frame.
module tb_uart_tx_scheduler;
  localparam int NR       = 4;
  localparam int DW       = 8;
  localparam int BUSY_LEN = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_last;
  logic [NR-1:0]  req_ready;
  logic [DW-1:0]  tx_data;
  logic           tx_start;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           pkt_active;
  logic [15:0]    byte_count;

  uart_tx_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .grant_id(grant_id),
    .pkt_active(pkt_active), .byte_count(byte_count)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // requester queues: {last, data}
  logic [8:0]    mem [NR][16];
  int            hd [NR];
  int            tl [NR];
  logic [NR-1:0] pend = '0;
  int            busy_cnt = 0;
  bit            force_busy = 1'b0;

  // issue log
  int   log_n = 0;
  int   log_gid [32];
  int   log_data [32];
  int   log_rdy [32];
  int   log_pkt [32];
  int   log_cyc [32];
  int   overlap = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // requester and transmitter model, updated away from the active edge
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_busy   = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (pend[i]) hd[i]++;
        pend[i] = req_ready[i];
        if (hd[i] != tl[i]) begin
          req_valid[i]         = 1'b1;
          req_data[i*DW +: DW] = mem[i][hd[i]][7:0];
          req_last[i]          = mem[i][hd[i]][8];
        end else begin
          req_valid[i]         = 1'b0;
          req_data[i*DW +: DW] = 8'h00;
          req_last[i]          = 1'b0;
        end
      end
      if (tx_start === 1'b1) busy_cnt = BUSY_LEN + 1;
      else if (busy_cnt > 0) busy_cnt--;
      tx_busy = force_busy || (busy_cnt > 0 && busy_cnt <= BUSY_LEN);
    end
  end

  // issue monitor
  initial forever begin
    @(negedge clk);
    if (tx_start === 1'b1) begin
      if (tx_busy === 1'b1) overlap++;
      if (log_n < 32) begin
        log_gid[log_n]  = int'(grant_id);
        log_data[log_n] = int'(tx_data);
        log_rdy[log_n]  = int'(req_ready);
        log_pkt[log_n]  = int'(pkt_active);
        log_cyc[log_n]  = cyc;
      end
      log_n++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    force_busy = 1'b0;
    busy_cnt   = 0;
    pend       = '0;
    for (int i = 0; i < NR; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
  endtask

  task automatic do_reset();
    sync();
    rst = 1'b1;
    clear_model();
    sync();
    sync();
    rst   = 1'b0;
    log_n = 0;
  endtask

  task automatic push(input int i, input logic last, input logic [7:0] d);
    mem[i][tl[i]] = {last, d};
    tl[i]++;
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (log_n < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk(tag, log_n, n);
  endtask

  task automatic wait_idle();
    repeat (20) @(negedge clk);
  endtask

  int c0;
  int base;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    // reset state
    chk("rst_tx_start", tx_start, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_pkt_active", pkt_active, 0);
    chk("rst_byte_count", byte_count, 0);

    // single request on requester 2
    do_reset();
    c0 = cyc;
    push(2, 1'b1, 8'hA5);
    wait_log(1, 40, "single_issue");
    chk("single_latency", log_cyc[0] - c0, 1);
    chk("single_data", log_data[0], 32'hA5);
    chk("single_ready", log_rdy[0], 32'h4);
    chk("single_gid", log_gid[0], 2);
    wait_idle();
    chk("single_count", byte_count, 1);
    chk("single_pkt", pkt_active, 0);

    // round robin, all single-byte packets
    do_reset();
    push(0, 1'b1, 8'h10);
    push(0, 1'b1, 8'h20);
    push(1, 1'b1, 8'h11);
    push(2, 1'b1, 8'h12);
    push(3, 1'b1, 8'h13);
    wait_log(5, 200, "rr_issues");
    chk("rr_g0", log_gid[0], 0);
    chk("rr_g1", log_gid[1], 1);
    chk("rr_g2", log_gid[2], 2);
    chk("rr_g3", log_gid[3], 3);
    chk("rr_g4", log_gid[4], 0);
    chk("rr_d1", log_data[1], 32'h11);
    chk("rr_d4", log_data[4], 32'h20);
    chk("rr_spacing", log_cyc[1] - log_cyc[0], 3 + BUSY_LEN);
    wait_idle();
    chk("rr_count", byte_count, 5);

    // packet lock: req0 three bytes while req1 waits
    do_reset();
    push(0, 1'b0, 8'h30);
    push(0, 1'b0, 8'h31);
    push(0, 1'b1, 8'h32);
    push(1, 1'b1, 8'h40);
    wait_log(4, 200, "lock_issues");
    chk("lock_g1", log_gid[1], 0);
    chk("lock_g2", log_gid[2], 0);
    chk("lock_g3", log_gid[3], 1);
    chk("lock_d2", log_data[2], 32'h32);
    chk("lock_d3", log_data[3], 32'h40);
    chk("lock_pkt0", log_pkt[0], 0);
    chk("lock_pkt1", log_pkt[1], 1);
    chk("lock_pkt2", log_pkt[2], 1);
    chk("lock_pkt3", log_pkt[3], 0);

    // owner stall: req0 locked with no valid, req3 waiting
    do_reset();
    push(0, 1'b0, 8'h50);
    push(3, 1'b1, 8'h60);
    wait_log(1, 40, "stall_first");
    repeat (30) @(negedge clk);
    chk("stall_no_start", log_n, 1);
    chk("stall_pkt", pkt_active, 1);
    sync();
    push(0, 1'b1, 8'h51);
    wait_log(3, 200, "stall_resume");
    chk("stall_g1", log_gid[1], 0);
    chk("stall_d1", log_data[1], 32'h51);
    chk("stall_g2", log_gid[2], 3);

    // busy block
    do_reset();
    force_busy = 1'b1;
    push(1, 1'b1, 8'h70);
    repeat (15) sync();
    chk("busy_block", log_n, 0);
    force_busy = 1'b0;
    @(negedge clk);
    chk("busy_fall_nostart", tx_start, 0);
    @(negedge clk);
    chk("busy_fall_start", tx_start, 1);
    chk("busy_fall_gid", grant_id, 1);
    chk("busy_fall_data", tx_data, 32'h70);
    wait_idle();

    // reset mid-packet, then restart from index 0
    do_reset();
    push(1, 1'b1, 8'h81);
    wait_log(1, 40, "mid_first");
    wait_idle();
    push(2, 1'b0, 8'h80);
    wait_log(2, 40, "mid_second");
    repeat (4) @(negedge clk);
    sync();
    rst = 1'b1;
    clear_model();
    sync();
    @(negedge clk);
    chk("mid_tx_start", tx_start, 0);
    chk("mid_req_ready", req_ready, 0);
    chk("mid_tx_data", tx_data, 0);
    chk("mid_grant_id", grant_id, 0);
    chk("mid_pkt_active", pkt_active, 0);
    chk("mid_byte_count", byte_count, 0);
    sync();
    rst = 1'b0;
    chk("mid_no_pulse", log_n, 2);
    push(0, 1'b1, 8'h90);
    push(2, 1'b1, 8'h91);
    wait_log(4, 200, "mid_restart");
    chk("mid_restart_g0", log_gid[2], 0);
    chk("mid_restart_d0", log_data[2], 32'h90);
    chk("mid_restart_g1", log_gid[3], 2);
    wait_idle();

    // counter wrap from a preloaded 0xFFFF
    dut.byte_count_r = 16'hFFFF;
    @(negedge clk);
    chk("wrap_preload", byte_count, 32'hFFFF);
    sync();
    push(1, 1'b1, 8'h99);
    wait_log(5, 40, "wrap_issue");
    chk("wrap_data", log_data[4], 32'h99);
    wait_idle();
    chk("wrap_count", byte_count, 0);

    chk("start_while_busy", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
